// File: rtl/avmm_apb_pkg.sv
// rtl/avmm_apb_pkg.sv - shared types and constants for the AVMM-to-APB bridge
package avmm_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEFAULT_TIMEOUT_RDATA = 32'hBADADD12;

endpackage

// File: rtl/avmm_slave_apb_master.sv
// rtl/avmm_slave_apb_master.sv - Avalon-MM slave to APB4 master bridge, one transfer outstanding
module avmm_slave_apb_master
  import avmm_apb_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 250,
  parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] avmm_address,
  input  logic                  avmm_read,
  input  logic                  avmm_write,
  input  logic [DATA_WIDTH-1:0] avmm_writedata,
  input  logic [3:0]            avmm_byteenable,
  output logic                  avmm_waitrequest,
  output logic [DATA_WIDTH-1:0] avmm_readdata,
  output logic                  avmm_readdatavalid,
  output logic                  avmm_writeresponsevalid,
  output logic [1:0]            avmm_response,
  output logic                  psel,
  output logic                  penable,
  output logic [31:0]           paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [3:0]            pstrb,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("avmm_slave_apb_master: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH > 32 || ADDR_WIDTH < 1) begin : g_bad_addr_width
    $error("avmm_slave_apb_master: ADDR_WIDTH must be 1..32");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("avmm_slave_apb_master: TIMEOUT_CYCLES must be >= 2");
  end

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic                  waitrequest_d;
  logic [DATA_WIDTH-1:0] readdata_d;
  logic                  readdatavalid_d;
  logic                  writeresponsevalid_d;
  logic [1:0]            response_d;
  logic                  psel_d;
  logic                  penable_d;
  logic [31:0]           paddr_d;
  logic                  pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic [3:0]            pstrb_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                 <= IDLE;
      timer_q                 <= '0;
      avmm_waitrequest        <= 1'b1;
      avmm_readdata           <= '0;
      avmm_readdatavalid      <= 1'b0;
      avmm_writeresponsevalid <= 1'b0;
      avmm_response           <= RESP_OKAY;
      psel                    <= 1'b0;
      penable                 <= 1'b0;
      paddr                   <= '0;
      pwrite                  <= 1'b0;
      pwdata                  <= '0;
      pstrb                   <= '0;
    end else begin
      state_q                 <= state_d;
      timer_q                 <= timer_d;
      avmm_waitrequest        <= waitrequest_d;
      avmm_readdata           <= readdata_d;
      avmm_readdatavalid      <= readdatavalid_d;
      avmm_writeresponsevalid <= writeresponsevalid_d;
      avmm_response           <= response_d;
      psel                    <= psel_d;
      penable                 <= penable_d;
      paddr                   <= paddr_d;
      pwrite                  <= pwrite_d;
      pwdata                  <= pwdata_d;
      pstrb                   <= pstrb_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    timer_d              = '0;
    waitrequest_d        = 1'b1;
    readdata_d           = avmm_readdata;
    readdatavalid_d      = 1'b0;
    writeresponsevalid_d = 1'b0;
    response_d           = avmm_response;
    psel_d               = psel;
    penable_d            = penable;
    paddr_d              = paddr;
    pwrite_d             = pwrite;
    pwdata_d             = pwdata;
    pstrb_d              = pstrb;

    unique case (state_q)
      IDLE: begin
        // A simultaneous read and write is resolved as a write.
        if (avmm_read || avmm_write) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          paddr_d  = 32'(avmm_address);
          pwrite_d = avmm_write;
          pwdata_d = avmm_writedata;
          pstrb_d  = avmm_write ? avmm_byteenable : 4'h0;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (pready) begin
          state_d       = DONE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          waitrequest_d = 1'b0;
          response_d    = pslverr ? RESP_SLVERR : RESP_OKAY;
          if (!pwrite) begin
            readdata_d = prdata;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d       = DONE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          waitrequest_d = 1'b0;
          response_d    = RESP_DECERR;
          if (!pwrite) begin
            readdata_d = TIMEOUT_RDATA;
          end
        end else begin
          timer_d = (&timer_q) ? timer_q : timer_q + TW'(1);
        end
      end

      DONE: begin
        state_d              = IDLE;
        readdatavalid_d      = !pwrite;
        writeresponsevalid_d = pwrite;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_avmm_slave_apb_master.sv
// tb/tb_avmm_slave_apb_master.sv - scoreboard bench for the AVMM-to-APB bridge
module tb_avmm_slave_apb_master;

  localparam int TIMEOUT = 250;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] avmm_address = '0;
  logic        avmm_read = 1'b0;
  logic        avmm_write = 1'b0;
  logic [31:0] avmm_writedata = '0;
  logic [3:0]  avmm_byteenable = '0;
  logic        avmm_waitrequest;
  logic [31:0] avmm_readdata;
  logic        avmm_readdatavalid;
  logic        avmm_writeresponsevalid;
  logic [1:0]  avmm_response;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;

  avmm_slave_apb_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TIMEOUT), .TIMEOUT_RDATA(32'hBADADD12)
  ) dut (
    .clk(clk), .rst(rst),
    .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
    .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
    .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid), .avmm_writeresponsevalid(avmm_writeresponsevalid),
    .avmm_response(avmm_response),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          exp_pulse_cyc = -1;

  logic [31:0] ref_mem[16];
  logic [31:0] comp_mem[16];
  logic [31:0] last_rd = '0;

  int          plan_waits = 0;
  bit          plan_err = 0;
  bit          plan_hang = 0;
  logic [31:0] exp_paddr = '0;
  logic        exp_pwrite = 1'b0;
  logic [31:0] exp_pwdata = '0;
  logic [3:0]  exp_pstrb = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // APB completer: wait states, error and hang are chosen per transfer by the driver.
  initial begin : completer
    int acc_cnt = 0;
    forever begin
      @(negedge clk);
      if (psel && penable) begin
        if (acc_cnt == 0 || (!plan_hang && acc_cnt == plan_waits)) begin
          chk("apb_paddr", paddr, exp_paddr);
          chk("apb_pwrite", 32'(pwrite), 32'(exp_pwrite));
          chk("apb_pstrb", 32'(pstrb), 32'(exp_pstrb));
          if (exp_pwrite) chk("apb_pwdata", pwdata, exp_pwdata);
        end
        if (!plan_hang && acc_cnt == plan_waits) begin
          pready  = 1'b1;
          pslverr = plan_err;
          if (pwrite) begin
            if (!plan_err) comp_mem[paddr[5:2]] = merge(comp_mem[paddr[5:2]], pwdata, pstrb);
            prdata = $urandom;
          end else begin
            prdata = comp_mem[paddr[5:2]];
          end
        end else begin
          pready  = 1'b0;
          pslverr = 1'($urandom);
          prdata  = $urandom;
        end
        acc_cnt++;
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
        acc_cnt = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (avmm_readdatavalid || avmm_writeresponsevalid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got rdv=%0b wrv=%0b expected none (cycle %0d)",
                   avmm_readdatavalid, avmm_writeresponsevalid, cyc);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", 32'({avmm_readdatavalid, avmm_writeresponsevalid}),
              e.is_wr ? 32'd1 : 32'd2);
          chk("response", 32'(avmm_response), 32'(e.resp));
          chk("readdata", avmm_readdata, e.rdata);
          chk("pulse_cycle", 32'(cyc), 32'(exp_pulse_cyc));
        end
      end
    end
  end

  // Issue one command (called just after a posedge); returns just after the posedge that accepted it.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int waits, input bit err, input bit hang);
    exp_t e;
    int   t0, acc;
    int   c_psel = -1;
    int   c_pen = -1;
    int   c_wr = -1;
    plan_waits = waits;
    plan_err   = err;
    plan_hang  = hang;
    exp_paddr  = addr;
    exp_pwrite = wr;
    exp_pwdata = wd;
    exp_pstrb  = wr ? be : 4'h0;
    acc        = hang ? TIMEOUT : waits + 1;

    e.is_wr = wr;
    if (hang) begin
      e.resp = 2'b11;
      if (!wr) last_rd = 32'hBADADD12;
    end else begin
      e.resp = err ? 2'b10 : 2'b00;
      if (!wr) last_rd = ref_mem[addr[5:2]];
      else if (!err) ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], wd, be);
    end
    e.rdata = last_rd;
    sb.push_back(e);

    avmm_address    = addr;
    avmm_read       = rd;
    avmm_write      = wr;
    avmm_writedata  = wd;
    avmm_byteenable = be;
    t0 = cyc;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (psel && c_psel < 0) c_psel = cyc;
      if (penable && c_pen < 0) c_pen = cyc;
      if (!avmm_waitrequest) begin
        c_wr = cyc;
        chk("apb_idle_when_accepted", 32'({psel, penable}), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    avmm_read  = 1'b0;
    avmm_write = 1'b0;
    exp_pulse_cyc = c_wr + 1;
    chk("psel_latency", 32'(c_psel - t0), 32'd1);
    chk("penable_latency", 32'(c_pen - t0), 32'd2);
    chk("accept_latency", 32'(c_wr - t0), 32'(2 + acc));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d errors", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] a;
    int          k;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]  = $urandom;
      comp_mem[i] = ref_mem[i];
    end
    ref_mem[1]  = 32'h12345678;
    comp_mem[1] = 32'h12345678;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", 32'(avmm_waitrequest), 32'd1);
    chk("rst_rdv", 32'(avmm_readdatavalid), 32'd0);
    chk("rst_wrv", 32'(avmm_writeresponsevalid), 32'd0);
    chk("rst_response", 32'(avmm_response), 32'd0);
    chk("rst_readdata", avmm_readdata, 32'd0);
    chk("rst_psel_penable", 32'({psel, penable}), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_pstrb", 32'(pstrb), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    txn(0, 1, 32'h100, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    txn(1, 0, 32'h204, 32'h0, 4'hF, 3, 0, 0);
    txn(1, 0, 32'h100, 32'h0, 4'h0, 1, 1, 0);
    txn(1, 0, 32'h300, 32'h0, 4'h0, 0, 0, 1);
    txn(0, 1, 32'h304, 32'h0BADF00D, 4'hF, 0, 0, 0);

    // Reset in the middle of an access: no response, bridge returns to idle.
    plan_hang  = 1;
    exp_paddr  = 32'h40;
    exp_pwrite = 1'b0;
    exp_pstrb  = 4'h0;
    avmm_address = 32'h40;
    avmm_read    = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_in_access", 32'({psel, penable}), 32'd3);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    avmm_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_psel_penable", 32'({psel, penable}), 32'd0);
    chk("midrst_waitrequest", 32'(avmm_waitrequest), 32'd1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    last_rd   = '0;
    plan_hang = 0;
    repeat (3) @(posedge clk);
    #1;
    txn(0, 1, 32'h44, 32'h13579BDF, 4'hF, 2, 0, 0);

    txn(1, 1, 32'h8, 32'hA5A55A5A, 4'h3, 0, 0, 0);
    txn(1, 0, 32'h8, 32'h0, 4'h0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      a[1:0] = 2'b00;
      k = $urandom_range(0, 2);
      txn(k != 1, k != 0, a, $urandom, 4'($urandom), $urandom_range(0, 4),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
